// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between ALU and LSU writebacks, LSU-first with ALU anti-starvation
module wb_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_rd_addr,
  output logic [DATA_W-1:0] rf_rd_din,
  output logic [3:0]        starve_cnt
);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  logic alu_nz, lsu_nz, alu_win, lsu_win;
  always_comb begin
    alu_nz = alu_valid & (|alu_rd);
    lsu_nz = lsu_valid & (|lsu_rd);
    alu_win = alu_nz & (~lsu_nz | (starve_cnt == SMAX));
    lsu_win = lsu_nz & ~alu_win;
    alu_ready = ~rst & alu_valid & (~(|alu_rd) | alu_win);
    lsu_ready = ~rst & lsu_valid & (~(|lsu_rd) | lsu_win);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we <= 1'b0;
      rf_rd_addr <= '0;
      rf_rd_din <= '0;
      starve_cnt <= '0;
    end else begin
      starve_cnt <= (alu_nz & ~alu_win) ? ((starve_cnt == SMAX) ? SMAX : starve_cnt + 4'd1) : 4'd0;
      rf_we <= alu_win | lsu_win;
      if (alu_win | lsu_win) begin
        rf_rd_addr <= alu_win ? alu_rd : lsu_rd;
        rf_rd_din <= alu_win ? alu_data : lsu_data;
      end
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: vector table, directed corner sequences and randomized traffic against a rule-level model
module tb_wb_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SM = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic alu_valid, alu_ready, lsu_valid, lsu_ready, rf_we;
  logic [AW-1:0] alu_rd, lsu_rd, rf_rd_addr;
  logic [DW-1:0] alu_data, lsu_data, rf_rd_din;
  logic [3:0] starve_cnt;
  int total = 0;
  int bad = 0;

  wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_rd_din(rf_rd_din), .starve_cnt(starve_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic av; logic [AW-1:0] ar; logic [DW-1:0] ad;
    logic lv; logic [AW-1:0] lr; logic [DW-1:0] ld;
    logic e_ar; logic e_lr; logic [3:0] e_st;
    logic e_we; logic [AW-1:0] e_addr; logic [DW-1:0] e_din;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drv(input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                     input logic lv, input logic [AW-1:0] lr, input logic [DW-1:0] ld);
    alu_valid = av; alu_rd = ar; alu_data = ad;
    lsu_valid = lv; lsu_rd = lr; lsu_data = ld;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  vec_t vt[7];
  bit pa_v, pl_v, m_we, a_acc, l_acc, a_req, l_req, a_g, l_g;
  logic [AW-1:0] pa_rd, pl_rd, m_addr;
  logic [DW-1:0] pa_d, pl_d, m_din;
  int m_losses;

  initial begin
    // reset state, then a write accepted just before reset must be dropped
    drv(1, 3, 32'hA5A5A5A5, 0, 0, 0);
    #2;
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_lsu_ready", lsu_ready, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_addr", rf_rd_addr, 0);
    chk("rst_din", rf_rd_din, 0);
    chk("rst_starve", starve_cnt, 0);
    tick;
    rst = 0;
    #1;
    chk("t1_alu_ready", alu_ready, 1);
    tick;
    chk("t1_we_pre", rf_we, 1);
    chk("t1_addr_pre", rf_rd_addr, 3);
    rst = 1;
    #1;
    chk("t1_we_rst", rf_we, 0);
    chk("t1_addr_rst", rf_rd_addr, 0);
    chk("t1_din_rst", rf_rd_din, 0);
    drv(0, 0, 0, 0, 0, 0);
    tick;
    rst = 0;
    tick;
    chk("t1_no_x3_we", rf_we, 0);
    chk("t1_no_x3_addr", rf_rd_addr, 0);

    vt[0] = '{1, 7, 32'h12345678, 0, 0, 0,          1, 0, 0, 1, 7, 32'h12345678};
    vt[1] = '{0, 0, 0,            0, 0, 0,          0, 0, 0, 0, 7, 32'h12345678};
    vt[2] = '{1, 0, 32'hDEAD,     1, 5, 32'h55,     1, 1, 0, 1, 5, 32'h55};
    vt[3] = '{1, 0, 32'hBEEF,     1, 0, 32'h66,     1, 1, 0, 0, 5, 32'h55};
    vt[4] = '{1, 9, 32'h1,        1, 9, 32'h2,      0, 1, 0, 1, 9, 32'h2};
    vt[5] = '{1, 9, 32'h1,        0, 0, 0,          1, 0, 1, 1, 9, 32'h1};
    vt[6] = '{0, 0, 0,            1, 4, 32'h44,     0, 1, 0, 1, 4, 32'h44};
    for (int i = 0; i < 7; i++) begin
      drv(vt[i].av, vt[i].ar, vt[i].ad, vt[i].lv, vt[i].lr, vt[i].ld);
      #1;
      chk($sformatf("v%0d_alu_ready", i), alu_ready, vt[i].e_ar);
      chk($sformatf("v%0d_lsu_ready", i), lsu_ready, vt[i].e_lr);
      chk($sformatf("v%0d_starve", i), starve_cnt, vt[i].e_st);
      tick;
      chk($sformatf("v%0d_we", i), rf_we, vt[i].e_we);
      chk($sformatf("v%0d_addr", i), rf_rd_addr, vt[i].e_addr);
      chk($sformatf("v%0d_din", i), rf_rd_din, vt[i].e_din);
    end

    // contention: LSU wins four times, then the starved ALU is forced through
    for (int i = 0; i < 10; i++) begin
      bit ea;
      ea = (i % 5) == 4;
      drv(1, 1, 32'hA0000000 + i, 1, 2, 32'hB0000000 + i);
      #1;
      chk($sformatf("c%0d_alu_ready", i), alu_ready, ea);
      chk($sformatf("c%0d_lsu_ready", i), lsu_ready, !ea);
      chk($sformatf("c%0d_starve", i), starve_cnt, i % 5);
      tick;
      chk($sformatf("c%0d_we", i), rf_we, 1);
      chk($sformatf("c%0d_addr", i), rf_rd_addr, ea ? 1 : 2);
      chk($sformatf("c%0d_din", i), rf_rd_din, ea ? 32'hA0000000 + i : 32'hB0000000 + i);
    end
    chk("c_starve_after", starve_cnt, 0);

    // back-to-back LSU writes at full throughput
    for (int i = 1; i <= 8; i++) begin
      drv(0, 0, 0, 1, AW'(i), 32'h11 * i);
      #1;
      chk($sformatf("b%0d_lsu_ready", i), lsu_ready, 1);
      chk($sformatf("b%0d_starve", i), starve_cnt, 0);
      tick;
      chk($sformatf("b%0d_we", i), rf_we, 1);
      chk($sformatf("b%0d_addr", i), rf_rd_addr, i);
    end
    drv(0, 0, 0, 0, 0, 0);

    rst = 1;
    tick;
    rst = 0;
    m_losses = 0; m_we = 0; m_addr = 0; m_din = 0;
    pa_v = 0; pl_v = 0; pa_rd = 0; pl_rd = 0; pa_d = 0; pl_d = 0;
    a_acc = 1; l_acc = 1;
    for (int n = 0; n < 400; n++) begin
      if (a_acc || !pa_v) begin
        pa_v = ($urandom % 4) != 0; pa_rd = AW'($urandom % 8); pa_d = $urandom;
      end
      if (l_acc || !pl_v) begin
        pl_v = ($urandom % 4) != 0; pl_rd = AW'($urandom % 8); pl_d = $urandom;
      end
      drv(pa_v, pa_rd, pa_d, pl_v, pl_rd, pl_d);
      #1;
      a_req = pa_v && pa_rd != 0;
      l_req = pl_v && pl_rd != 0;
      a_g = a_req && (!l_req || m_losses == SM);
      l_g = l_req && !a_g;
      a_acc = pa_v && (pa_rd == 0 || a_g);
      l_acc = pl_v && (pl_rd == 0 || l_g);
      chk("r_alu_ready", alu_ready, a_acc);
      chk("r_lsu_ready", lsu_ready, l_acc);
      chk("r_starve", starve_cnt, m_losses);
      tick;
      m_losses = (a_req && !a_g) ? ((m_losses < SM) ? m_losses + 1 : SM) : 0;
      m_we = a_g || l_g;
      if (a_g) begin m_addr = pa_rd; m_din = pa_d; end
      if (l_g) begin m_addr = pl_rd; m_din = pl_d; end
      chk("r_we", rf_we, m_we);
      chk("r_addr", rf_rd_addr, m_addr);
      chk("r_din", rf_rd_din, m_din);
      if (rf_we) chk("r_we_addr_nonzero", rf_rd_addr != 0, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
